// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - circular-buffer pointer, status and error control for a 2^ADDR_WIDTH register file
module fifo_ctrl #(
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

    // One extra pointer bit distinguishes full from empty when the addresses match.
    logic [ADDR_WIDTH:0] wp;
    logic [ADDR_WIDTH:0] rp;
    logic                push_ok;
    logic                pop_ok;
    logic                ovf_evt;
    logic                udf_evt;

    assign w_addr       = wp[ADDR_WIDTH-1:0];
    assign r_addr       = rp[ADDR_WIDTH-1:0];
    assign empty        = (wp == rp);
    assign full         = (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]) &&
                          (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]);
    assign count        = wp - rp;
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);

    assign push_ok = wr & ~full;
    assign pop_ok  = rd & ~empty;
    assign ovf_evt = wr & full & ~flush;
    assign udf_evt = rd & empty & ~flush;

    // Flush and reset suppress the write strobe so the register file never sees a dropped push.
    assign w_en = push_ok & ~flush & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push_ok) wp <= wp + PTR_ONE;
                if (pop_ok)  rp <= rp + PTR_ONE;
            end
            // A new error in the same cycle as clr_err keeps the flag set.
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (udf_evt)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard bench for fifo_ctrl against a queue-based FIFO model
module tb_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int AF_TH = 6;
    localparam int AE_TH = 1;

    logic          clk = 1'b0;
    logic          reset, wr, rd, flush, clr_err;
    logic          w_en, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW-1:0] w_addr, r_addr;
    logic [AW:0]   count;
    logic [7:0]    w_data;
    logic [7:0]    mem [DEPTH];

    typedef struct {
        logic          w_en;
        int            w_addr;
        int            r_addr;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        int            count;
        logic          ovf;
        logic          udf;
        int            head;
    } exp_t;

    exp_t exp_q[$];
    int   model_q[$];
    int   wr_total, rd_total;
    logic m_ovf, m_udf;
    int   checks = 0;
    int   errors = 0;

    fifo_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .flush(flush), .clr_err(clr_err),
        .w_en(w_en), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (w_en) mem[w_addr] <= w_data;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs for this cycle come from the model state before the edge,
    // then the model advances by the FIFO rules.
    task automatic step(input logic i_rst, input logic i_fl, input logic i_ce,
                        input logic i_wr, input logic i_rd, input logic [7:0] d);
        exp_t e;
        int   n;
        logic push_ok, pop_ok;
        reset = i_rst; flush = i_fl; clr_err = i_ce; wr = i_wr; rd = i_rd; w_data = d;
        n        = model_q.size();
        e.full   = (n == DEPTH);
        e.empty  = (n == 0);
        e.af     = (n >= AF_TH);
        e.ae     = (n <= AE_TH);
        e.count  = n;
        e.w_addr = wr_total % DEPTH;
        e.r_addr = rd_total % DEPTH;
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        e.head   = (n > 0) ? model_q[0] : 0;
        e.w_en   = i_wr && (n != DEPTH) && !i_fl && !i_rst;
        exp_q.push_back(e);
        if (i_rst) begin
            model_q.delete();
            wr_total = 0; rd_total = 0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            if (i_wr && n == DEPTH && !i_fl) m_ovf = 1'b1;
            else if (i_ce)                   m_ovf = 1'b0;
            if (i_rd && n == 0 && !i_fl)     m_udf = 1'b1;
            else if (i_ce)                   m_udf = 1'b0;
            if (i_fl) begin
                model_q.delete();
                wr_total = 0; rd_total = 0;
            end else begin
                push_ok = i_wr && (n != DEPTH);
                pop_ok  = i_rd && (n != 0);
                if (pop_ok)  begin void'(model_q.pop_front()); rd_total++; end
                if (push_ok) begin model_q.push_back(int'(d)); wr_total++; end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("w_en", int'(w_en), int'(e.w_en));
                check("w_addr", int'(w_addr), e.w_addr);
                check("r_addr", int'(r_addr), e.r_addr);
                check("full", int'(full), int'(e.full));
                check("empty", int'(empty), int'(e.empty));
                check("almost_full", int'(almost_full), int'(e.af));
                check("almost_empty", int'(almost_empty), int'(e.ae));
                check("count", int'(count), e.count);
                check("overflow", int'(overflow), int'(e.ovf));
                check("underflow", int'(underflow), int'(e.udf));
                if (!e.empty) check("r_data", int'(mem[r_addr]), e.head);
            end
        end
    end

    initial begin : driver
        int p_wr, p_rd;
        reset = 1'b1; flush = 1'b0; clr_err = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        wr_total = 0; rd_total = 0; m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 8'h00);
        // fill to full, then one rejected push
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 8'(8'hA0 + i));
        step(0, 0, 0, 1, 0, 8'hEE);
        // drain, then one rejected pop
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        // wrap-around from pointer 5
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 8'(8'h20 + i));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'h00);
        // simultaneous at count 3, at full, at empty
        step(0, 0, 0, 1, 1, 8'h30);
        step(0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 8'(8'h40 + i));
        step(0, 0, 0, 1, 1, 8'h4F);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 1, 8'h50);
        // flush with pending push at count 4 and overflow set
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 8'(8'h60 + i));
        step(0, 1, 0, 1, 0, 8'h6F);
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        // reset mid-stream with wr & rd
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 8'(8'h70 + i));
        step(1, 0, 0, 1, 1, 8'h7F);
        step(0, 0, 0, 0, 0, 8'h00);
        // randomized traffic with shifting push/pop bias
        p_wr = 50; p_rd = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                p_wr = $urandom_range(10, 90);
                p_rd = $urandom_range(10, 90);
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 99) < p_wr),
                 ($urandom_range(0, 99) < p_rd), 8'($urandom_range(0, 255)));
        end
        step(0, 0, 0, 0, 0, 8'h00);
        @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
